// File: rtl/laser_pkg.sv
// Shared definitions for the multi-channel laser pulse generator.
//   - Channel FSM state encoding (IDLE / FIRE / COOL; 2'b11 is illegal).
//   - Default parameter values used by laser_pulse_gen and laser_pulse_ch.
package laser_pkg;

  localparam int DEFAULT_CHANNELS = 4;
  localparam int DEFAULT_CNT_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FIRE = 2'b01,
    ST_COOL = 2'b10
  } state_e;

endpackage : laser_pkg

// File: rtl/laser_pulse_ch.sv
// One laser channel: three-state FSM (IDLE/FIRE/COOL), a down-counter and
// Mealy output logic. The laser enable rises in the same cycle as the trigger.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   b_i          trigger level for this channel
//   pulse_len_i  high cycles per pulse including the trigger cycle (0 = disabled)
//   cooldown_i   forced-low cycles after a pulse (0 = none)
//   retrig_i     trigger during FIRE restarts the length count
//   abort_i      synchronous kill, also masks outputs combinationally
//   x_o          laser enable
//   busy_o       state is not IDLE
//   missed_o     trigger seen during COOL (dropped)
module laser_pulse_ch
  import laser_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             b_i,
  input  logic [CNT_W-1:0] pulse_len_i,
  input  logic [CNT_W-1:0] cooldown_i,
  input  logic             retrig_i,
  input  logic             abort_i,
  output logic             x_o,
  output logic             busy_o,
  output logic             missed_o
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Where a pulse goes once its high phase ends.
  state_e           exit_state;
  logic             len_ok;
  logic             len_multi;

  assign exit_state = (cooldown_i != CNT_ZERO) ? ST_COOL : ST_IDLE;
  assign len_ok     = (pulse_len_i != CNT_ZERO);
  assign len_multi  = (pulse_len_i > CNT_ONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic. cnt holds the cycles remaining after the
  // current one, so a load of N-1 yields N cycles in total.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abort_i) begin
      state_d = ST_IDLE;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (b_i && len_ok) begin
            if (len_multi) begin
              state_d = ST_FIRE;
              cnt_d   = pulse_len_i - CNT_ONE;
            end else begin
              // Single-cycle pulse: the trigger cycle is the whole pulse.
              state_d = exit_state;
              cnt_d   = cooldown_i;
            end
          end
        end
        ST_FIRE: begin
          if (retrig_i && b_i) begin
            if (len_multi) begin
              cnt_d = pulse_len_i - CNT_ONE;
            end else begin
              state_d = exit_state;
              cnt_d   = cooldown_i;
            end
          end else if (cnt_q <= CNT_ONE) begin
            state_d = exit_state;
            cnt_d   = cooldown_i;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_COOL: begin
          if (cnt_q <= CNT_ONE) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // Mealy outputs, gated by reset so they drop the moment rst_n falls.
  always_comb begin
    x_o      = 1'b0;
    missed_o = 1'b0;
    busy_o   = rst_n && (state_q != ST_IDLE);
    if (rst_n && !abort_i) begin
      case (state_q)
        ST_IDLE: x_o      = b_i && len_ok;
        ST_FIRE: x_o      = 1'b1;
        ST_COOL: missed_o = b_i;
        default: x_o      = 1'b0;
      endcase
    end
  end

endmodule : laser_pulse_ch

// File: rtl/laser_pulse_gen.sv
// Multi-channel laser pulse generator. Each bit of b drives an independent
// channel; pulse length, cooldown, retrigger mode and abort are shared.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   b          per-channel trigger level
//   pulse_len  high cycles per pulse (0 disables triggering)
//   cooldown   low cycles after each pulse (0 = none)
//   retrig     trigger during FIRE restarts the length count
//   abort      synchronous kill of all channels
//   x          per-channel laser enable
//   busy       per-channel state is not IDLE
//   missed     per-channel trigger dropped during cooldown
module laser_pulse_gen
  import laser_pkg::*;
#(
  parameter int CHANNELS = DEFAULT_CHANNELS,
  parameter int CNT_W    = DEFAULT_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] b,
  input  logic [CNT_W-1:0]    pulse_len,
  input  logic [CNT_W-1:0]    cooldown,
  input  logic                retrig,
  input  logic                abort,
  output logic [CHANNELS-1:0] x,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] missed
);

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      laser_pulse_ch #(
        .CNT_W (CNT_W)
      ) u_ch (
        .clk         (clk),
        .rst_n       (rst_n),
        .b_i         (b[gi]),
        .pulse_len_i (pulse_len),
        .cooldown_i  (cooldown),
        .retrig_i    (retrig),
        .abort_i     (abort),
        .x_o         (x[gi]),
        .busy_o      (busy[gi]),
        .missed_o    (missed[gi])
      );
    end
  endgenerate

endmodule : laser_pulse_gen

// File: tb/tb_laser_pulse_gen.sv
// Self-checking bench for laser_pulse_gen: directed scenarios with constant
// expectations plus a randomized run against a per-channel behavioural model
// that tracks "high cycles left" and "cooldown cycles left" as plain integers.
module tb_laser_pulse_gen;

  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] b;
  logic [7:0]     pulse_len;
  logic [7:0]     cooldown;
  logic           retrig;
  logic           abort;
  logic [NCH-1:0] x;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] missed;

  int n_checks = 0;
  int n_errors = 0;

  // Model state.
  int hi_left   [NCH];
  int cool_left [NCH];
  // Per-channel activity counters for directed scenarios.
  int x_cnt     [NCH];
  int busy_cnt  [NCH];
  int miss_cnt  [NCH];
  logic [NCH-1:0] last_x, last_busy;

  always #5 clk = ~clk;

  laser_pulse_gen #(.CHANNELS(NCH), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .b         (b),
    .pulse_len (pulse_len),
    .cooldown  (cooldown),
    .retrig    (retrig),
    .abort     (abort),
    .x         (x),
    .busy      (busy),
    .missed    (missed)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NCH; i++) begin
      x_cnt[i] = 0; busy_cnt[i] = 0; miss_cnt[i] = 0;
    end
  endtask

  // One clock cycle. Called just after a falling edge with inputs already set.
  task automatic cycle();
    logic [NCH-1:0] ex, eb, em;
    for (int i = 0; i < NCH; i++) begin
      eb[i] = rst_n && (hi_left[i] > 0 || cool_left[i] > 0);
      em[i] = rst_n && !abort && cool_left[i] > 0 && hi_left[i] == 0 && b[i];
      if (!rst_n || abort)         ex[i] = 1'b0;
      else if (hi_left[i] > 0)     ex[i] = 1'b1;
      else if (cool_left[i] > 0)   ex[i] = 1'b0;
      else                         ex[i] = b[i] && (pulse_len != 0);
    end
    #1;
    check("x", 32'(x), 32'(ex));
    check("busy", 32'(busy), 32'(eb));
    check("missed", 32'(missed), 32'(em));
    last_x = x; last_busy = busy;
    for (int i = 0; i < NCH; i++) begin
      x_cnt[i]    += int'(x[i]);
      busy_cnt[i] += int'(busy[i]);
      miss_cnt[i] += int'(missed[i]);
    end
    @(posedge clk);
    // Model update: a pulse of N cycles leaves N-1 after the trigger cycle,
    // and reaching zero high cycles starts the cooldown.
    for (int i = 0; i < NCH; i++) begin
      if (!rst_n || abort) begin
        hi_left[i] = 0; cool_left[i] = 0;
      end else if (hi_left[i] > 0) begin
        if (retrig && b[i] && pulse_len > 1) begin
          hi_left[i] = int'(pulse_len) - 1;
        end else begin
          if (retrig && b[i]) hi_left[i] = 0;
          else                hi_left[i] = hi_left[i] - 1;
          if (hi_left[i] == 0) cool_left[i] = int'(cooldown);
        end
      end else if (cool_left[i] > 0) begin
        cool_left[i] = cool_left[i] - 1;
      end else if (b[i] && pulse_len != 0) begin
        hi_left[i] = int'(pulse_len) - 1;
        if (hi_left[i] == 0) cool_left[i] = int'(cooldown);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    b = '0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    rst_n = 1'b0; b = '0; pulse_len = 8'd3; cooldown = 8'd0;
    retrig = 1'b0; abort = 1'b0;
    for (int i = 0; i < NCH; i++) begin hi_left[i] = 0; cool_left[i] = 0; end
    clear_counts();
    @(negedge clk);
    b = '1;
    cycle(); cycle();
    check("reset_x", 32'(x), 32'(0));
    rst_n = 1'b1;
    idle(2);

    // Default pulse on channel 0.
    clear_counts();
    b = 4'b0001; cycle();
    idle(6);
    check("dflt_x_cycles", 32'(x_cnt[0]), 32'd3);
    check("dflt_busy_cycles", 32'(busy_cnt[0]), 32'd2);
    $display("txn default pulse: x=%0d busy=%0d", x_cnt[0], busy_cnt[0]);

    // Held trigger with cooldown on channel 1.
    pulse_len = 8'd2; cooldown = 8'd3; clear_counts();
    for (int k = 0; k < 10; k++) begin b = 4'b0010; cycle(); end
    check("cool_x_cycles", 32'(x_cnt[1]), 32'd4);
    check("cool_missed_cycles", 32'(miss_cnt[1]), 32'd6);
    $display("txn cooldown: x=%0d missed=%0d", x_cnt[1], miss_cnt[1]);
    idle(6);

    // Retrigger extension vs. ignored retrigger on channel 2.
    pulse_len = 8'd4; cooldown = 8'd0;
    for (int r = 1; r >= 0; r--) begin
      retrig = r[0]; clear_counts();
      b = 4'b0100; cycle(); idle(1);
      b = 4'b0100; cycle(); idle(8);
      check(r ? "retrig_on_len" : "retrig_off_len", 32'(x_cnt[2]), r ? 32'd6 : 32'd4);
      $display("txn retrig=%0d: x=%0d", r, x_cnt[2]);
    end
    retrig = 1'b0;

    // Abort during a long pulse on all channels.
    pulse_len = 8'd10; clear_counts();
    b = '1; cycle(); idle(3);
    abort = 1'b1; b = '1; cycle();
    check("abort_x", 32'(last_x), 32'd0);
    abort = 1'b0; b = '0; cycle();
    check("abort_busy", 32'(last_busy), 32'd0);
    idle(4);
    check("abort_x_cycles", 32'(x_cnt[3]), 32'd4);
    $display("txn abort: x=%0d", x_cnt[3]);

    // Edge lengths: 0, 1, 255.
    pulse_len = 8'd0; clear_counts();
    for (int k = 0; k < 5; k++) begin b = '1; cycle(); end
    check("len0_x_cycles", 32'(x_cnt[0]), 32'd0);
    pulse_len = 8'd1; clear_counts();
    b = 4'b0001; cycle(); idle(3);
    check("len1_x_cycles", 32'(x_cnt[0]), 32'd1);
    pulse_len = 8'd255; clear_counts();
    b = 4'b0001; cycle(); idle(260);
    check("len255_x_cycles", 32'(x_cnt[0]), 32'd255);
    $display("txn edge lengths: len255 x=%0d", x_cnt[0]);

    // Reset mid-pulse drops x at once; afterwards a fresh full pulse.
    pulse_len = 8'd5; clear_counts();
    b = 4'b0001; cycle(); idle(1);
    rst_n = 1'b0;
    #1;
    check("rst_async_x", 32'(x), 32'd0);
    check("rst_async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    cycle();
    rst_n = 1'b1; clear_counts();
    b = 4'b0001; cycle(); idle(7);
    check("rst_fresh_x_cycles", 32'(x_cnt[0]), 32'd5);
    $display("txn reset mid-pulse: x=%0d", x_cnt[0]);

    // Randomized run against the model.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) pulse_len = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 19) == 0) cooldown  = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 29) == 0) retrig    = 1'($urandom_range(0, 1));
      abort = ($urandom_range(0, 39) == 0);
      b     = NCH'($urandom & $urandom);
      if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      cycle();
    end
    $display("txn random run done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_laser_pulse_gen

// File: doc/laser_pulse_gen.md
# laser_pulse_gen

Multi-channel, parametrised successor to the single-channel three-cycle laser pulse FSM. Each channel fires a Mealy-style pulse, with `x` high in the same cycle as the trigger. Pulse length and post-pulse cooldown are run-time programmable, with optional retrigger (pulse extension) and a global abort. The block sits between the debounced button/trigger inputs and the laser driver enables.

## Interface
- `CHANNELS`, default 4: number of independent trigger/laser channels (≥1).
- `CNT_W`, default 8: width of the length and cooldown counters; max programmable value 2^CNT_W−1.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `b`  in  CHANNELS  per-channel trigger, level, sampled each cycle.
- `pulse_len`  in  CNT_W  laser-high cycles per pulse, counted including the trigger cycle; 0 disables triggering.
- `cooldown`  in  CNT_W  forced-low cycles after a pulse; 0 means no cooldown.
- `retrig`  in  1  1: trigger during FIRE restarts the length count.
- `abort`  in  1  synchronous kill of all channels.
- `x`  out  CHANNELS  laser enable per channel.
- `busy`  out  CHANNELS  channel state ≠ IDLE.
- `missed`  out  CHANNELS  trigger arrived while in COOL and was dropped.

## Operation
- Per channel: states IDLE, FIRE, COOL, plus a CNT_W-bit down-counter `cnt`. `cnt` holds the remaining high/low cycles after the current one.
- `pulse_len` and `cooldown` are sampled only at load time. Changes mid-pulse do not affect the running count.
- **IDLE**, `b[i]`=1, `pulse_len`≠0, `abort`=0:
  - `x[i]`=1 combinationally in this cycle.
  - If `pulse_len`>1: next FIRE, `cnt`←`pulse_len`−1.
  - Else: exit, as defined below.
- **IDLE**, otherwise: `x[i]`=0; state stays IDLE.
- **FIRE**: `x[i]`=1.
  - If `retrig`=1 and `b[i]`=1: reload `cnt`←`pulse_len`−1 and stay in FIRE. If `pulse_len`≤1, exit instead.
  - Else if `cnt`=1: exit.
  - Else: `cnt`←`cnt`−1.
  - With `retrig`=0, `b[i]` is ignored in FIRE.
- **Exit**: if `cooldown`≠0, next COOL with `cnt`←`cooldown`; else next IDLE.
- **COOL**: `x[i]`=0.
  - `missed[i]`=`b[i]`, combinational; the trigger is dropped.
  - If `cnt`=1: next IDLE; else `cnt`←`cnt`−1.
- **abort**=1: `x`=0 and `missed`=0 combinationally in all channels. Every channel goes to IDLE with `cnt`←0 at the next edge. Triggers in the abort cycle are discarded.
- Illegal state encoding: next IDLE, `x`=0.
- Channels are fully independent; simultaneous triggers on all channels are legal.

## Timing
- Reset, while `rst_n`=0: state IDLE, `cnt`=0. `x`, `busy` and `missed` are forced to 0 (outputs gated by `rst_n`).
- Reset assertion mid-pulse drops `x` immediately (asynchronous). After release the channel is in IDLE.
- Trigger-to-`x` latency is 0 cycles (Mealy). `busy` rises 1 cycle after the trigger.
- A pulse with `retrig`=0 is exactly `pulse_len` cycles high, then `cooldown` cycles low before re-arm.
  - Earliest retrigger from IDLE: cycle `pulse_len`+`cooldown` after the first trigger.
- A held-high `b` with `cooldown`=0 produces back-to-back pulses with no gap.
- Counter arithmetic is unsigned CNT_W. The only reachable values are 1…2^CNT_W−1, so no wrap.

## Structure
- Shared package `laser_pkg`: state encodings `ST_IDLE`=2'b00, `ST_FIRE`=2'b01, `ST_COOL`=2'b10, plus the default `CNT_W`.
- Sub-module `laser_pulse_ch`: one channel (FSM + counter + Mealy output logic).
  - `laser_pulse_gen` instantiates it CHANNELS times in a generate loop and fans out `pulse_len`, `cooldown`, `retrig` and `abort`.

## Test plan
- **Default pulse:** `pulse_len`=3, `cooldown`=0, one-cycle `b[0]` at cycle 10 → `x[0]`=1 in cycles 10–12, 0 at cycle 13; `busy[0]` high in cycles 11–12.
- **Cooldown/missed:** `pulse_len`=2, `cooldown`=3, `b[1]` held high → `x[1]` pattern 1,1,0,0,0,1,1,…; `missed[1]`=1 during the 3 low cycles.
- **Retrigger:** `pulse_len`=4, `retrig`=1, `b[2]` at cycles 0 and 2 → `x[2]` high in cycles 0–5 (6 cycles). Same stimulus with `retrig`=0 → high in cycles 0–3.
- **Abort:** `pulse_len`=10 on all channels, `abort` at cycle 4 → all `x`=0 at cycle 4; all `busy`=0 at cycle 5; a `b` in cycle 4 is ignored.
- **Edge values:** `pulse_len`=0 → no `x` ever. `pulse_len`=1 → single-cycle `x`. `pulse_len`=255 (CNT_W=8) → exactly 255 high cycles.
- **Reset mid-pulse:** `rst_n` low at cycle 2 of a 5-cycle pulse → `x` falls asynchronously; after release `b` triggers a fresh full pulse.
